prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Board-side program/data loader: user-driven writer into the unified instruction/data RAM that the load/store CPU FSM reads.
- Operator assembles 16-bit words from switches, one byte at a time, and commits them with push-buttons. Words land at an auto-incrementing address.
- Holds the CPU off (cpu_hold) while loading. Releases it on a RUN command.
- Runs on the same clock domain as the RAM write port.

Parameters:
- DEBOUNCE_CYCLES, 250000, cycles a synchronized key level must stay stable before it is accepted (5 ms at 50 MHz).
- ADDR_W, 10, RAM address width; address wraps modulo 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- sw  input  10  sw[7:0] data/address byte; sw[9] mode (0 = data, 1 = set address); sw[8] unused
- key_n  input  2  raw active-low buttons: key_n[0] ENTER, key_n[1] RUN
- mem_dout  input  16  RAM read data, 1-cycle read latency (used only with the optional feature)
- mem_addr  output  ADDR_W  RAM address
- mem_din  output  16  RAM write data
- mem_we  output  1  RAM write enable, one-cycle pulse
- cpu_hold  output  1  high = CPU FSM/PC held; low = CPU running
- word_count  output  ADDR_W  words written since reset; saturates at all-ones
- state_dbg  output  3  current FSM state encoding
- err  output  1  sticky readback mismatch flag

Behaviour:
- Reset (reset==0 at a clk edge) sets:
  - state LOAD_LO, mem_addr 0, mem_din 0, lo_byte 0
  - mem_we 0, cpu_hold 1, word_count 0, err 0
  - debouncers to "released"
- Per-key input path:
  - 2-FF synchronizer.
  - Debounce counter restarts on any change of the synchronized level. The level is accepted after DEBOUNCE_CYCLES consecutive stable cycles.
  - A press event is a 1-cycle pulse on the accepted level going 1->0. Release produces no event.
  - Latency from a stable raw press to the event: DEBOUNCE_CYCLES+3 cycles.
- Priority: if ENTER and RUN events occur in the same cycle, RUN wins and ENTER is discarded.
- State encoding: LOAD_LO=0, LOAD_HI=1, WRITE=2, VERIFY=3, RUN=4.
- LOAD_LO:
  - ENTER with sw[9]=1: mem_addr <= zero-extended sw[7:0]; stay in LOAD_LO.
  - ENTER with sw[9]=0: lo_byte <= sw[7:0]; go to LOAD_HI.
  - RUN: go to RUN.
- LOAD_HI:
  - ENTER: mem_din <= {sw[7:0], lo_byte} (sw[9] ignored); go to WRITE.
  - RUN: discard the partial word and go to RUN.
- WRITE:
  - mem_we=1 for exactly this one cycle; mem_addr and mem_din are stable during it.
  - Next state: LOAD_LO (or VERIFY with the optional feature).
  - On leaving the word path, mem_addr increments with wrap (all-ones -> 0) and word_count increments, saturating.
  - Key events arriving in WRITE are dropped.
- RUN:
  - cpu_hold=0 during this state; mem_we=0; ENTER ignored.
  - RUN event: go to LOAD_LO, cpu_hold returns to 1 on the same edge, mem_addr is preserved.
- cpu_hold is registered: 0 exactly while state==RUN.
- mem_we is asserted only in WRITE.
- Reset asserted mid-WRITE: mem_we is 0 after that edge, with no address or count increment.

Optional Feature:
- Macro: PROG_LOADER_READBACK_EN.
- Defined:
  - WRITE goes to VERIFY, which lasts 2 cycles with mem_addr held.
  - On the second VERIFY cycle, mem_dout is compared with mem_din; a mismatch sets err=1.
  - err is sticky and cleared only by reset.
  - mem_addr and word_count then increment and the FSM goes to LOAD_LO.
  - Key events during VERIFY are dropped.
- Undefined:
  - VERIFY is unreachable; WRITE goes straight to LOAD_LO with the increment.
  - err is tied to 0 and mem_dout is unused.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4.
- Reset, then press ENTER (sw=0x034), then ENTER (sw=0x012) -> one mem_we pulse with addr 0x000, din 0x1234; afterwards mem_addr=1, word_count=1, cpu_hold=1.
- ENTER with sw=0x210 (set address 0x10), then load word 0xBEEF -> write at 0x010; mem_addr becomes 0x011.
- Raw key_n[0] bouncing 1-0-1-0 with 2-cycle glitches, then stable low for 10 cycles -> exactly one ENTER event; no event on release.
- Set mem_addr to 0x3FF via repeated loads, then write one word -> write at 0x3FF, mem_addr wraps to 0x000.
- ENTER and RUN pressed in the same cycle in LOAD_HI -> goes to RUN, cpu_hold=0, no mem_we; a second RUN -> LOAD_LO, cpu_hold=1, address unchanged.
- With PROG_LOADER_READBACK_EN, the RAM model corrupts bit 0 on read -> err=1 after the second VERIFY cycle and stays 1 until reset.

Source files
------------

// File: rtl/prog_loader.sv
// Switch/button driven word loader for the unified CPU RAM; holds the CPU while loading.
// Optional write-readback check enabled by defining PROG_LOADER_READBACK_EN.
module prog_loader #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ADDR_W          = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        sw,
  input  logic [1:0]        key_n,
  input  logic [15:0]       mem_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] word_count,
  output logic [2:0]        state_dbg,
  output logic              err
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    LOAD_LO = 3'd0,
    LOAD_HI = 3'd1,
    WRITE   = 3'd2,
    VERIFY  = 3'd3,
    RUN     = 3'd4
  } state_t;

  logic [1:0] press_ev;

  // Per key: 2-FF sync, stability counter, then a registered falling-edge pulse.
  for (genvar gi = 0; gi < 2; gi++) begin : g_key
    logic             sync1_q, sync2_q, acc_q, acc_prev_q, ev_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (!reset) begin
        sync1_q    <= 1'b1;
        sync2_q    <= 1'b1;
        acc_q      <= 1'b1;
        acc_prev_q <= 1'b1;
        ev_q       <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q    <= key_n[gi];
        sync2_q    <= sync1_q;
        acc_prev_q <= acc_q;
        ev_q       <= acc_prev_q & ~acc_q;
        if (sync2_q != acc_q) begin
          if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            acc_q <= sync2_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end

    assign press_ev[gi] = ev_q;
  end

  logic run_ev, enter_ev;
  assign run_ev   = press_ev[1];
  assign enter_ev = press_ev[0] & ~press_ev[1];

  state_t            state_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] word_count_q;
  logic [15:0]       mem_din_q;
  logic [7:0]        lo_byte_q;
  logic              mem_we_q;
  logic              cpu_hold_q;
`ifdef PROG_LOADER_READBACK_EN
  logic              verify_phase_q;
  logic              err_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= LOAD_LO;
      mem_addr_q   <= '0;
      word_count_q <= '0;
      mem_din_q    <= '0;
      lo_byte_q    <= '0;
      mem_we_q     <= 1'b0;
      cpu_hold_q   <= 1'b1;
`ifdef PROG_LOADER_READBACK_EN
      verify_phase_q <= 1'b0;
      err_q          <= 1'b0;
`endif
    end else begin
      case (state_q)
        LOAD_LO: begin
          if (run_ev) begin
            state_q    <= RUN;
            cpu_hold_q <= 1'b0;
          end else if (enter_ev) begin
            if (sw[9]) begin
              mem_addr_q <= ADDR_W'(sw[7:0]);
            end else begin
              lo_byte_q <= sw[7:0];
              state_q   <= LOAD_HI;
            end
          end
        end
        LOAD_HI: begin
          if (run_ev) begin
            state_q    <= RUN;
            cpu_hold_q <= 1'b0;
          end else if (enter_ev) begin
            mem_din_q <= {sw[7:0], lo_byte_q};
            mem_we_q  <= 1'b1;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          mem_we_q <= 1'b0;
`ifdef PROG_LOADER_READBACK_EN
          verify_phase_q <= 1'b0;
          state_q        <= VERIFY;
`else
          mem_addr_q <= mem_addr_q + ADDR_W'(1);
          if (word_count_q != '1) word_count_q <= word_count_q + ADDR_W'(1);
          state_q <= LOAD_LO;
`endif
        end
`ifdef PROG_LOADER_READBACK_EN
        // First cycle presents the address; read data is valid on the second.
        VERIFY: begin
          if (!verify_phase_q) begin
            verify_phase_q <= 1'b1;
          end else begin
            if (mem_dout != mem_din_q) err_q <= 1'b1;
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
            if (word_count_q != '1) word_count_q <= word_count_q + ADDR_W'(1);
            state_q <= LOAD_LO;
          end
        end
`endif
        RUN: begin
          if (run_ev) begin
            state_q    <= LOAD_LO;
            cpu_hold_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= LOAD_LO;
          mem_we_q   <= 1'b0;
          cpu_hold_q <= 1'b1;
        end
      endcase
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_we     = mem_we_q;
  assign cpu_hold   = cpu_hold_q;
  assign word_count = word_count_q;
  assign state_dbg  = state_q;

`ifdef PROG_LOADER_READBACK_EN
  assign err = err_q;
  logic unused_sw;
  assign unused_sw = sw[8];
`else
  assign err = 1'b0;
  logic unused_in;
  assign unused_in = ^{sw[8], mem_dout};
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a 1-cycle-latency RAM model.
module tb_prog_loader;
  localparam int D  = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [9:0]    sw = '0;
  logic [1:0]    key_n = 2'b11;
  logic [15:0]   mem_dout;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic          mem_we;
  logic          cpu_hold;
  logic [AW-1:0] word_count;
  logic [2:0]    state_dbg;
  logic          err;

  int checks = 0;
  int passes = 0;

  prog_loader #(.DEBOUNCE_CYCLES(D), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .sw(sw), .key_n(key_n), .mem_dout(mem_dout),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .cpu_hold(cpu_hold),
    .word_count(word_count), .state_dbg(state_dbg), .err(err)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [0:(1<<AW)-1];
  logic        corrupt = 1'b0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr] ^ {15'd0, corrupt};
  end

  int          we_cnt = 0;
  logic [9:0]  last_addr = '0;
  logic [15:0] last_din = '0;
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      we_cnt++;
      last_addr = mem_addr;
      last_din  = mem_din;
      $display("write addr=%h din=%h", mem_addr, mem_din);
    end
  end

  task automatic press(input logic [1:0] keys);
    @(negedge clk);
    key_n = ~keys;
    repeat (8) @(negedge clk);
    key_n = 2'b11;
    repeat (8) @(negedge clk);
  endtask

  task automatic write_word(input logic [15:0] w);
    sw = {2'b00, w[7:0]};
    press(2'b01);
    sw = {2'b00, w[15:8]};
    press(2'b01);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (state_dbg !== 3'd0) $display("FAIL reset_state got=%0d want=0", state_dbg); else passes++;
    checks++; if (mem_addr !== 10'h000) $display("FAIL reset_addr got=%h want=000", mem_addr); else passes++;
    checks++; if (mem_din !== 16'h0000) $display("FAIL reset_din got=%h want=0000", mem_din); else passes++;
    checks++; if (mem_we !== 1'b0) $display("FAIL reset_we got=%b want=0", mem_we); else passes++;
    checks++; if (cpu_hold !== 1'b1) $display("FAIL reset_hold got=%b want=1", cpu_hold); else passes++;
    checks++; if (word_count !== 10'd0) $display("FAIL reset_count got=%0d want=0", word_count); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err got=%b want=0", err); else passes++;
  endtask

  task automatic test_basic_word;
    int w0;
    w0 = we_cnt;
    write_word(16'h1234);
    checks++; if (we_cnt !== w0 + 1) $display("FAIL basic_we_pulses got=%0d want=%0d", we_cnt - w0, 1); else passes++;
    checks++; if (last_addr !== 10'h000) $display("FAIL basic_waddr got=%h want=000", last_addr); else passes++;
    checks++; if (last_din !== 16'h1234) $display("FAIL basic_wdata got=%h want=1234", last_din); else passes++;
    checks++; if (mem_addr !== 10'h001) $display("FAIL basic_addr_inc got=%h want=001", mem_addr); else passes++;
    checks++; if (word_count !== 10'd1) $display("FAIL basic_count got=%0d want=1", word_count); else passes++;
    checks++; if (cpu_hold !== 1'b1) $display("FAIL basic_hold got=%b want=1", cpu_hold); else passes++;
    $display("basic word: addr=%h count=%0d", mem_addr, word_count);
  endtask

  task automatic test_set_addr;
    sw = 10'h210;
    press(2'b01);
    checks++; if (mem_addr !== 10'h010) $display("FAIL setaddr_addr got=%h want=010", mem_addr); else passes++;
    checks++; if (state_dbg !== 3'd0) $display("FAIL setaddr_state got=%0d want=0", state_dbg); else passes++;
    write_word(16'hBEEF);
    checks++; if (last_addr !== 10'h010) $display("FAIL setaddr_waddr got=%h want=010", last_addr); else passes++;
    checks++; if (last_din !== 16'hBEEF) $display("FAIL setaddr_wdata got=%h want=beef", last_din); else passes++;
    checks++; if (mem_addr !== 10'h011) $display("FAIL setaddr_next got=%h want=011", mem_addr); else passes++;
    checks++; if (word_count !== 10'd2) $display("FAIL setaddr_count got=%0d want=2", word_count); else passes++;
  endtask

  task automatic test_bounce;
    int w0;
    w0 = we_cnt;
    sw = 10'h0CD;
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      key_n[0] = g[0];
      repeat (2) @(negedge clk);
    end
    key_n[0] = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (state_dbg !== 3'd1) $display("FAIL bounce_one_event got=%0d want=1", state_dbg); else passes++;
    key_n[0] = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (state_dbg !== 3'd1) $display("FAIL bounce_release got=%0d want=1", state_dbg); else passes++;
    checks++; if (we_cnt !== w0) $display("FAIL bounce_no_write got=%0d want=%0d", we_cnt, w0); else passes++;
    sw = 10'h0AB;
    press(2'b01);
    checks++; if (last_din !== 16'hABCD) $display("FAIL bounce_wdata got=%h want=abcd", last_din); else passes++;
    checks++; if (last_addr !== 10'h011) $display("FAIL bounce_waddr got=%h want=011", last_addr); else passes++;
    checks++; if (word_count !== 10'd3) $display("FAIL bounce_count got=%0d want=3", word_count); else passes++;
  endtask

  task automatic test_wrap;
    sw = 10'h2FF;
    press(2'b01);
    checks++; if (mem_addr !== 10'h0FF) $display("FAIL wrap_setaddr got=%h want=0ff", mem_addr); else passes++;
    for (int i = 0; i < 800 && mem_addr !== 10'h3FF; i++) write_word(16'(i));
    checks++; if (mem_addr !== 10'h3FF) $display("FAIL wrap_reach_top got=%h want=3ff", mem_addr); else passes++;
    checks++; if (word_count !== 10'd771) $display("FAIL wrap_fill_count got=%0d want=771", word_count); else passes++;
    write_word(16'h5A5A);
    checks++; if (last_addr !== 10'h3FF) $display("FAIL wrap_waddr got=%h want=3ff", last_addr); else passes++;
    checks++; if (mem_addr !== 10'h000) $display("FAIL wrap_addr got=%h want=000", mem_addr); else passes++;
    checks++; if (word_count !== 10'd772) $display("FAIL wrap_count got=%0d want=772", word_count); else passes++;
    $display("wrap: addr=%h count=%0d", mem_addr, word_count);
  endtask

  task automatic test_run_priority;
    int w0;
    sw = 10'h077;
    press(2'b01);
    checks++; if (state_dbg !== 3'd1) $display("FAIL run_pre_state got=%0d want=1", state_dbg); else passes++;
    w0 = we_cnt;
    sw = 10'h000;
    press(2'b11);
    checks++; if (state_dbg !== 3'd4) $display("FAIL run_state got=%0d want=4", state_dbg); else passes++;
    checks++; if (cpu_hold !== 1'b0) $display("FAIL run_hold got=%b want=0", cpu_hold); else passes++;
    checks++; if (we_cnt !== w0) $display("FAIL run_no_write got=%0d want=%0d", we_cnt, w0); else passes++;
    press(2'b01);
    checks++; if (state_dbg !== 3'd4) $display("FAIL run_enter_ignored got=%0d want=4", state_dbg); else passes++;
    press(2'b10);
    checks++; if (state_dbg !== 3'd0) $display("FAIL run_exit_state got=%0d want=0", state_dbg); else passes++;
    checks++; if (cpu_hold !== 1'b1) $display("FAIL run_exit_hold got=%b want=1", cpu_hold); else passes++;
    checks++; if (mem_addr !== 10'h000) $display("FAIL run_addr_kept got=%h want=000", mem_addr); else passes++;
    checks++; if (word_count !== 10'd772) $display("FAIL run_count_kept got=%0d want=772", word_count); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL run_err got=%b want=0", err); else passes++;
  endtask

`ifdef PROG_LOADER_READBACK_EN
  task automatic test_readback;
    corrupt = 1'b1;
    write_word(16'h1111);
    checks++; if (last_addr !== 10'h000) $display("FAIL rb_waddr got=%h want=000", last_addr); else passes++;
    checks++; if (err !== 1'b1) $display("FAIL rb_err_set got=%b want=1", err); else passes++;
    checks++; if (mem_addr !== 10'h001) $display("FAIL rb_addr_inc got=%h want=001", mem_addr); else passes++;
    corrupt = 1'b0;
    write_word(16'h2222);
    checks++; if (err !== 1'b1) $display("FAIL rb_err_sticky got=%b want=1", err); else passes++;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (err !== 1'b0) $display("FAIL rb_err_clear got=%b want=0", err); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_word();
    test_set_addr();
    test_bounce();
    test_wrap();
    test_run_priority();
`ifdef PROG_LOADER_READBACK_EN
    test_readback();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
